// File: rtl/oh_simcheck.sv
// Scoreboard checker: loads expected words or runs an LFSR, compares DUT beats.
// Optional watchdog: define OH_SIMCHECK_WATCHDOG_EN.
module oh_simcheck #(
  parameter int          DW    = 32,
  parameter int          DEPTH = 256,
  parameter int          NRAND = 1024,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          WDOG  = 1024
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [2:0]    mode,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          dut_valid,
  input  logic [DW-1:0] dut_data,
  output logic          dut_ready,
  output logic          dut_done,
  output logic          dut_fail,
  output logic [15:0]   err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int NW = (NRAND > 0) ? $clog2(NRAND + 1) : 1;
  localparam int WW = (WDOG > 0) ? $clog2(WDOG + 1) : 1;
  localparam logic [PW-1:0] FULL  = DEPTH[PW-1:0];
  localparam logic [NW-1:0] NLAST = NRAND[NW-1:0];
  localparam logic [WW-1:0] WLIM  = WDOG[WW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [NW-1:0] r_beats;
  logic [31:0]   r_lfsr;
  logic          r_rng;
  logic          r_fail;
  logic [15:0]   r_err;
  logic          r_cmp_v;
  logic [DW-1:0] r_cmp_a;
  logic [DW-1:0] r_cmp_b;

  logic          w_empty;
  logic          w_ready;
  logic          w_acc;
  logic          w_full;
  logic          w_wr;
  logic          w_ovf;
  logic          w_enter;
  logic          w_mis;
  logic          w_fb;
  logic          w_wdog_hit;
  logic [DW-1:0] w_exp;

  assign w_empty = r_rng ? (r_beats == NLAST)
                         : (r_rd_ptr == r_wr_ptr);
  assign w_ready = (r_state == S_CHECK) & ~w_empty;
  assign w_acc   = dut_valid & w_ready;
  assign w_full  = (r_wr_ptr == FULL);
  assign w_wr    = (r_state == S_LOAD) & load_valid & ~w_full;
  assign w_ovf   = (r_state == S_LOAD) & load_valid & w_full;
  assign w_enter = ((r_state == S_IDLE) | (r_state == S_LOAD))
                 & ((mode == 3'd2) | (mode == 3'd3));
  assign w_exp   = r_rng ? r_lfsr[DW-1:0]
                         : r_mem[r_rd_ptr[AW-1:0]];
  assign w_fb    = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
  assign w_mis   = r_cmp_v & (r_cmp_a != r_cmp_b);

`ifdef OH_SIMCHECK_WATCHDOG_EN
  logic [WW-1:0] r_wdog;

  assign w_wdog_hit = (r_state == S_CHECK) & (r_wdog == WLIM);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wdog <= '0;
    end else if ((r_state != S_CHECK) | w_acc) begin
      r_wdog <= '0;
    end else if (!w_wdog_hit) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  logic w_unused_wdog;

  assign w_wdog_hit    = 1'b0;
  assign w_unused_wdog = ^WLIM;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        case (mode)
          3'd1:       w_next = S_LOAD;
          3'd2, 3'd3: w_next = S_CHECK;
          3'd4:       w_next = S_DONE;
          default:    w_next = S_IDLE;
        endcase
      end
      S_LOAD: begin
        case (mode)
          3'd2, 3'd3: w_next = S_CHECK;
          3'd4:       w_next = S_DONE;
          default:    w_next = S_LOAD;
        endcase
      end
      S_CHECK: begin
        if (w_empty | w_wdog_hit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory has no reset; contents are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_beats  <= '0;
      r_lfsr   <= SEED;
      r_rng    <= 1'b0;
      r_fail   <= 1'b0;
      r_err    <= '0;
      r_cmp_v  <= 1'b0;
      r_cmp_a  <= '0;
      r_cmp_b  <= '0;
    end else begin
      r_state <= w_next;
      r_cmp_v <= w_acc;
      if (w_enter) r_rng <= (mode == 3'd3);
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_acc) begin
        r_cmp_a <= dut_data;
        r_cmp_b <= w_exp;
        if (r_rng) begin
          r_beats <= r_beats + 1'b1;
          r_lfsr  <= {r_lfsr[30:0], w_fb};
        end else begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
      if (w_mis && (r_err != 16'hFFFF)) r_err <= r_err + 1'b1;
      if (w_mis | w_ovf | w_wdog_hit) r_fail <= 1'b1;
    end
  end

  assign dut_ready = w_ready;
  assign dut_done  = (r_state == S_DONE);
  assign dut_fail  = r_fail;
  assign err_count = r_err;

endmodule

// File: doc/oh_simcheck.md
OH_SIMCHECK -- requirements
Module: oh_simcheck

Interface
REQ-001 Parameter DW, default 32: width of checked data; SHALL be 1..32.
REQ-002 Parameter DEPTH, default 256: expected-data memory entries (power of 2).
REQ-003 Parameter NRAND, default 1024: beats checked in rng mode.
REQ-004 Parameter SEED, default 32'h0000_0001: LFSR seed; SHALL be nonzero.
REQ-005 Parameter WDOG, default 1024: watchdog limit in cycles.
REQ-006 clk  in  1  main clock; all logic on rising edge.
REQ-007 nreset  in  1  async active-low reset.
REQ-008 mode  in  3  sim phase: 0=idle, 1=load, 2=go, 3=rng, 4=bypass; 5-7 treated as idle.
REQ-009 load_valid  in  1  expected word present in load phase.
REQ-010 load_data  in  DW  expected word.
REQ-011 dut_valid  in  1  DUT result beat valid.
REQ-012 dut_data  in  DW  DUT result beat.
REQ-013 dut_ready  out  1  checker accepts beat; beat transfers when dut_valid & dut_ready.
REQ-014 dut_done  out  1  test complete; sticky until reset.
REQ-015 dut_fail  out  1  mismatch/overflow/timeout seen; sticky until reset.
REQ-016 err_count  out  16  mismatch count, saturating at 16'hFFFF.

Function
REQ-017 FSM states IDLE, LOAD, CHECK, DONE; mode sampled every cycle.
REQ-018 IDLE: mode=1 -> LOAD; mode=2 or 3 -> CHECK; mode=4 -> DONE; otherwise stay.
REQ-019 LOAD: each load_valid cycle writes load_data to mem[wr_ptr], wr_ptr+1.
REQ-020 load_valid with wr_ptr==DEPTH: word dropped, dut_fail set, wr_ptr holds.
REQ-021 LOAD: mode=2 or 3 -> CHECK; mode=4 -> DONE; mode=0 -> stay LOAD (writes kept).
REQ-022 CHECK latches sub-mode (go or rng) on entry; later mode changes ignored until DONE.
REQ-023 dut_ready = 1 only in CHECK; 0 in all other states and in reset.
REQ-024 go: accepted beat compared to mem[rd_ptr], rd_ptr+1.
REQ-025 rng: accepted beat compared to LFSR[DW-1:0]; LFSR x^32+x^22+x^2+x+1, loaded with SEED at reset, advanced once per accepted beat.
REQ-026 Compare registered: beat accepted at edge N -> err_count/dut_fail updated at edge N+1.
REQ-027 Mismatch: err_count+1 (saturating), dut_fail <= 1.
REQ-028 go completes when rd_ptr reaches wr_ptr; rng completes after NRAND accepted beats.
REQ-029 Completion: dut_ready falls the cycle after the last beat; DONE and dut_done=1 at edge N+1 with final dut_fail/err_count.
REQ-030 Go entered with wr_ptr==0: DONE next cycle, dut_fail unchanged.
REQ-031 Bypass (mode=4): DONE next cycle, no data checked, dut_fail unchanged.
REQ-032 DONE absorbing until nreset; dut_valid ignored.
REQ-033 DW<32: LFSR bits [31:DW] excluded from compare; unused mem bits not stored.

Reset
REQ-034 nreset low asynchronously sets: state IDLE, dut_ready=0, dut_done=0, dut_fail=0, err_count=0, wr_ptr=0, rd_ptr=0, LFSR=SEED, watchdog=0.
REQ-035 Reset mid-LOAD or mid-CHECK discards all progress; memory contents undefined, not read before rewrite.
REQ-036 Release synchronous to clk; first state change no earlier than first edge after release.

Configuration
REQ-037 Macro OH_SIMCHECK_WATCHDOG_EN defined: in CHECK, counter clears on each accepted beat, else increments; reaching WDOG -> DONE with dut_fail=1 next cycle.
REQ-038 Macro undefined: no watchdog counter in RTL; CHECK waits indefinitely.

Verification
REQ-039 Load 4 words 1,2,3,4; mode=2; DUT sends 1,2,3,4 -> dut_done=1 one cycle after 4th beat, dut_fail=0, err_count=0.
REQ-040 Same load; DUT sends 1,9,3,8 -> dut_done=1, dut_fail=1, err_count=2.
REQ-041 mode=3, NRAND=16, DUT runs same LFSR from SEED=1 -> dut_done after 16th beat, dut_fail=0; flip bit 0 of beat 5 -> err_count=1.
REQ-042 Load DEPTH+1 words -> dut_fail=1 immediately after last; wr_ptr=DEPTH.
REQ-043 mode=4 from IDLE -> dut_done=1 next cycle, dut_fail=0; nreset pulse mid-CHECK -> all outputs zero, FSM IDLE.
REQ-044 OH_SIMCHECK_WATCHDOG_EN, WDOG=8, CHECK with dut_valid=0 -> dut_done=1, dut_fail=1 at cycle 9; macro undefined -> dut_done stays 0.
